lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store access unit sitting directly upstream of the dual-port data memory in the multi-cycle core. It accepts one load or store request at a time from the execute/control path and drives the memory's read/write port. Stores narrower than 64 bits use read-modify-write because the memory always writes a full doubleword. Load data is extracted, sign- or zero-extended, and returned through a valid/ready response.

## Interface
- `BASE_ADDR`, default 64'h8000_0000: lowest legal data address, used only for the range check.
- `MEM_SIZE`, default 4096: memory depth in doublewords, used only for the range check.
- `iClock` in 1: core clock; all state changes on the rising edge.
- `iReset` in 1: asynchronous, active-low reset.
- `iReqValid` in 1: a request is present on the `iReq*` lines.
- `oReqReady` out 1: the unit accepts a request this cycle; high only in IDLE.
- `iReqWr` in 1: 1 = store, 0 = load.
- `iReqSize` in 2: access size; 0 = B, 1 = H, 2 = W, 3 = D.
- `iReqSigned` in 1: for loads, 1 = sign-extend, 0 = zero-extend.
- `iReqAddr` in 64: byte address.
- `iReqWrData` in 64: store data, right-aligned.
- `oRespValid` out 1: a response is presented.
- `iRespReady` in 1: the consumer takes the response this cycle.
- `oRespData` out 64: extended load data; 0 for stores and faults.
- `oRespFault` out 1: the request was misaligned or out of range; no memory access was made.
- `oMemRdEn` out 1: memory read enable.
- `oMemWrEn` out 1: memory write enable.
- `oMemAddr` out 64: `{addr[63:3], 3'b000}`.
- `oMemWrData` out 64: full merged doubleword to write.
- `oMemWrByt` out 10: write-size code; always 10'd4 (doubleword) when `oMemWrEn` is high, 0 otherwise.
- `iMemRdData` in 64: memory read data, valid one cycle after `oMemRdEn` and address are presented.

## Operation
- **States:** IDLE, RD, CAP, WR, RESP.
- **Accept:** a request is accepted on a clock edge where `iReqValid` & `oReqReady` are both high. At that edge the request is latched, and `off = addr[2:0]`, `shift = off*8`.
- **Fault check at accept** (fault when either holds):
  - `off` is not a multiple of 2^size;
  - the address is outside `[BASE_ADDR, BASE_ADDR + 8*MEM_SIZE)`.
  - On fault: IDLE→RESP with `oRespFault` = 1 and no memory enables.
- **IDLE transitions:**
  - load → RD;
  - store with size D → WR (no read);
  - store with size B/H/W → RD.
- **RD:** `oMemRdEn` = 1 with `oMemAddr` driven. Next state is CAP.
- **CAP:** `oMemRdEn` and `oMemAddr` are held. `iMemRdData` is registered at the end of this cycle.
  - Load: result = `(rd >> shift)` truncated to the access size, then extended per `iReqSigned` (for size D, `iReqSigned` is ignored). Next state is RESP.
  - Store: `mask` = ones in the access bytes `<< shift`; `merged = (rd & ~mask) | ((wrdata << shift) & mask)`. Next state is WR.
- **WR:** one cycle with `oMemWrEn` = 1, `oMemWrByt` = 4, `oMemWrData` = merged (or the raw `iReqWrData` for a D store). Next state is RESP.
- **RESP:** `oRespValid` = 1. `oRespData` and `oRespFault` stay stable until `iRespReady`; on the handshake edge the state returns to IDLE.
- **Back-to-back:** no request is accepted in the same cycle as the response handshake. The earliest next accept is in the cycle after the handshake.
- **Reset:** asserting reset at any time forces IDLE immediately (asynchronous). All memory enables drop at once and any in-flight store is abandoned without writing.

## Timing
- **Reset values:**
  - `oReqReady` = 1.
  - All other outputs = 0: `oRespValid`, `oRespData`, `oRespFault`, `oMemRdEn`, `oMemWrEn`, `oMemAddr`, `oMemWrData`, `oMemWrByt`.
- **Response latency**, counted in cycles from the accept edge to the first cycle `oRespValid` is high:
  - load: 3;
  - partial store: 4;
  - D store: 2;
  - fault: 1.
- All outputs are registered or decoded from state only. There are no combinational paths from `iReq*` or `iMemRdData` to any output.
- `oMemAddr` is held constant from RD through WR.
- When `iRespReady` is held low, the unit stays in RESP indefinitely with its outputs stable.

## Structure
- **Shared package `lsu_pkg`:**
  - state enum;
  - size encodings `SZ_B/H/W/D`;
  - memory write-size codes `MEM_BYT_B = 1`, `H = 2`, `W = 3`, `D = 4`;
  - `BASE_ADDR` default.
- **Sub-module `lsu_align`:** purely combinational. It provides both the load extract/extend and the store merge/mask functions and is instantiated once. The FSM and registers live in `lsu_mem_port`.

## Test plan
All cases start with the memory doubleword at 0x8000_0008 = 0x1122_3344_5566_7788.

1. **Byte loads:** LB signed @0x8000_0008 → 0xFFFF_FFFF_FFFF_FF88. LBU @0x8000_000F → 0x11. Each response appears 3 cycles after accept, with `oMemRdEn` high for exactly 2 cycles.
2. **Half/word loads:** LHU @0x8000_000A → 0x5566. LW signed @0x8000_0008 → 0x0000_0000_5566_7788. LD → the full value.
3. **SB:** 0xAB @0x8000_0009 → RD, CAP, then a single write of 0x1122_3344_5566_AB88 with `oMemWrByt` = 4. Response 4 cycles after accept, `oRespData` = 0.
4. **SD:** 0xDEAD_BEEF @0x8000_0010 → `oMemRdEn` never asserted, one write cycle, response after 2 cycles.
5. **Faults:**
   - LH @0x8000_0009 → `oRespFault` = 1 next cycle, no memory enables.
   - LW @0x7FFF_FFF0 → fault.
6. **Backpressure:** hold `iRespReady` = 0 for 5 cycles → `oRespValid` and `oRespData` stable, `oReqReady` = 0.
7. **Reset mid-store:** assert reset in CAP of a store → enables drop asynchronously, the WR write never occurs, and `oReqReady` = 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory port.
package lsu_pkg;

   // Access-sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_WR   = 3'd3,
      ST_RESP = 3'd4
   } lsu_state_e;

   // Access size encodings
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   // Memory write-size codes
   localparam logic [9:0] MEM_BYT_B = 10'd1;
   localparam logic [9:0] MEM_BYT_H = 10'd2;
   localparam logic [9:0] MEM_BYT_W = 10'd3;
   localparam logic [9:0] MEM_BYT_D = 10'd4;

   // Default address window
   localparam logic [63:0] BASE_ADDR_DEF = 64'h0000_0000_8000_0000;
   localparam int unsigned MEM_SIZE_DEF  = 4096;

   // Right-aligned byte mask covering an access of the given size
   function automatic logic [63:0] size_mask(input logic [1:0] size);
      logic [63:0] m;
      case (size)
         SZ_B:    m = 64'h0000_0000_0000_00FF;
         SZ_H:    m = 64'h0000_0000_0000_FFFF;
         SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
         SZ_D:    m = 64'hFFFF_FFFF_FFFF_FFFF;
         default: m = 64'h0000_0000_0000_0000;
      endcase
      return m;
   endfunction

   // True when the byte offset is not a multiple of the access size
   function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
      logic r;
      case (size)
         SZ_B:    r = 1'b0;
         SZ_H:    r = off[0];
         SZ_W:    r = |off[1:0];
         SZ_D:    r = |off;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_mem_port_align.sv
// Combinational lane logic: load extract/extend and store read-modify-write merge.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_off,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [63:0] i_rd_data,
   input  logic [63:0] i_wr_data,
   output logic [63:0] o_load_data,
   output logic [63:0] o_merged
);

   logic [5:0]  w_shift;
   logic [63:0] w_rd_shifted;
   logic [63:0] w_mask;

   assign w_shift      = {i_off, 3'b000};
   assign w_rd_shifted = i_rd_data >> w_shift;
   assign w_mask       = size_mask(i_size) << w_shift;

   // Truncate the shifted read data to the access size and extend it
   always_comb begin
      o_load_data = w_rd_shifted;
      case (i_size)
         SZ_B: begin
            if (i_signed) o_load_data = {{56{w_rd_shifted[7]}}, w_rd_shifted[7:0]};
            else          o_load_data = {56'd0, w_rd_shifted[7:0]};
         end
         SZ_H: begin
            if (i_signed) o_load_data = {{48{w_rd_shifted[15]}}, w_rd_shifted[15:0]};
            else          o_load_data = {48'd0, w_rd_shifted[15:0]};
         end
         SZ_W: begin
            if (i_signed) o_load_data = {{32{w_rd_shifted[31]}}, w_rd_shifted[31:0]};
            else          o_load_data = {32'd0, w_rd_shifted[31:0]};
         end
         SZ_D:    o_load_data = w_rd_shifted;
         default: o_load_data = 64'd0;
      endcase
   end

   // Replace only the addressed bytes of the old doubleword with store data
   always_comb begin
      o_merged = (i_rd_data & ~w_mask) | ((i_wr_data << w_shift) & w_mask);
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store access unit: sequences one request at a time onto the data memory port.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR = BASE_ADDR_DEF,
   parameter int unsigned MEM_SIZE  = MEM_SIZE_DEF
)
(
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iReqValid,
   output logic        oReqReady,
   input  logic        iReqWr,
   input  logic [1:0]  iReqSize,
   input  logic        iReqSigned,
   input  logic [63:0] iReqAddr,
   input  logic [63:0] iReqWrData,
   output logic        oRespValid,
   input  logic        iRespReady,
   output logic [63:0] oRespData,
   output logic        oRespFault,
   output logic        oMemRdEn,
   output logic        oMemWrEn,
   output logic [63:0] oMemAddr,
   output logic [63:0] oMemWrData,
   output logic [9:0]  oMemWrByt,
   input  logic [63:0] iMemRdData
);

   localparam logic [63:0] LIMIT_ADDR = BASE_ADDR + (64'(MEM_SIZE) << 3);

   lsu_state_e  r_state;
   lsu_state_e  w_state_nxt;

   logic        r_wr;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [2:0]  r_off;
   logic [63:0] r_wr_data;

   logic        r_req_ready;
   logic        r_resp_valid;
   logic [63:0] r_resp_data;
   logic        r_resp_fault;
   logic        r_mem_rd_en;
   logic        r_mem_wr_en;
   logic [63:0] r_mem_addr;
   logic [63:0] r_mem_wr_data;
   logic [9:0]  r_mem_wr_byt;

   logic        w_accept;
   logic        w_fault;
   logic [63:0] w_load_data;
   logic [63:0] w_merged;

   assign w_accept = iReqValid & r_req_ready;
   assign w_fault  = is_misaligned(iReqAddr[2:0], iReqSize)
                   | (iReqAddr < BASE_ADDR)
                   | (iReqAddr >= LIMIT_ADDR);

   lsu_align u_align (
      .i_off       (r_off),
      .i_size      (r_size),
      .i_signed    (r_signed),
      .i_rd_data   (iMemRdData),
      .i_wr_data   (r_wr_data),
      .o_load_data (w_load_data),
      .o_merged    (w_merged)
   );

   // Next-state decode for the access sequencer
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_fault)                w_state_nxt = ST_RESP;
               else if (!iReqWr)           w_state_nxt = ST_RD;
               else if (iReqSize == SZ_D)  w_state_nxt = ST_WR;
               else                        w_state_nxt = ST_RD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RD:   w_state_nxt = ST_CAP;
         ST_CAP: begin
            if (r_wr) w_state_nxt = ST_WR;
            else      w_state_nxt = ST_RESP;
         end
         ST_WR:   w_state_nxt = ST_RESP;
         ST_RESP: begin
            if (iRespReady) w_state_nxt = ST_IDLE;
            else            w_state_nxt = ST_RESP;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Sequencer state register
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Registered outputs and request context, loaded from the upcoming state
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         r_wr          <= 1'b0;
         r_size        <= 2'd0;
         r_signed      <= 1'b0;
         r_off         <= 3'd0;
         r_wr_data     <= 64'd0;
         r_req_ready   <= 1'b1;
         r_resp_valid  <= 1'b0;
         r_resp_data   <= 64'd0;
         r_resp_fault  <= 1'b0;
         r_mem_rd_en   <= 1'b0;
         r_mem_wr_en   <= 1'b0;
         r_mem_addr    <= 64'd0;
         r_mem_wr_data <= 64'd0;
         r_mem_wr_byt  <= 10'd0;
      end else begin
         r_req_ready  <= (w_state_nxt == ST_IDLE);
         r_resp_valid <= (w_state_nxt == ST_RESP);
         r_mem_rd_en  <= (w_state_nxt == ST_RD) || (w_state_nxt == ST_CAP);
         r_mem_wr_en  <= (w_state_nxt == ST_WR);
         r_mem_wr_byt <= (w_state_nxt == ST_WR) ? MEM_BYT_D : 10'd0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_wr         <= iReqWr;
                  r_size       <= iReqSize;
                  r_signed     <= iReqSigned;
                  r_off        <= iReqAddr[2:0];
                  r_wr_data    <= iReqWrData;
                  r_resp_data  <= 64'd0;
                  r_resp_fault <= w_fault;
                  if (!w_fault) r_mem_addr <= {iReqAddr[63:3], 3'b000};
                  // A full-doubleword store skips the read and writes the raw data
                  if (!w_fault && iReqWr && (iReqSize == SZ_D)) r_mem_wr_data <= iReqWrData;
                  else                                           r_mem_wr_data <= 64'd0;
               end
            end
            ST_CAP: begin
               if (r_wr) r_mem_wr_data <= w_merged;
               else      r_resp_data   <= w_load_data;
            end
            ST_WR: begin
               r_mem_wr_data <= 64'd0;
            end
            ST_RESP: begin
               if (iRespReady) begin
                  r_resp_data  <= 64'd0;
                  r_resp_fault <= 1'b0;
               end
            end
            default: begin
               r_mem_wr_data <= 64'd0;
            end
         endcase
      end
   end

   assign oReqReady  = r_req_ready;
   assign oRespValid = r_resp_valid;
   assign oRespData  = r_resp_data;
   assign oRespFault = r_resp_fault;
   assign oMemRdEn   = r_mem_rd_en;
   assign oMemWrEn   = r_mem_wr_en;
   assign oMemAddr   = r_mem_addr;
   assign oMemWrData = r_mem_wr_data;
   assign oMemWrByt  = r_mem_wr_byt;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: behavioural memory/request model plus per-cycle compare.
module tb_lsu_mem_port;

   localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
   localparam logic [63:0] LIMIT = 64'h0000_0000_8000_8000;

   logic        clk = 1'b0;
   logic        iReset;
   logic        iReqValid, iReqWr, iReqSigned, iRespReady;
   logic [1:0]  iReqSize;
   logic [63:0] iReqAddr, iReqWrData;
   logic [63:0] iMemRdData;
   logic        oReqReady, oRespValid, oRespFault, oMemRdEn, oMemWrEn;
   logic [63:0] oRespData, oMemAddr, oMemWrData;
   logic [9:0]  oMemWrByt;

   lsu_mem_port dut (
      .iClock(clk), .iReset(iReset),
      .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqWr(iReqWr),
      .iReqSize(iReqSize), .iReqSigned(iReqSigned), .iReqAddr(iReqAddr),
      .iReqWrData(iReqWrData), .oRespValid(oRespValid), .iRespReady(iRespReady),
      .oRespData(oRespData), .oRespFault(oRespFault), .oMemRdEn(oMemRdEn),
      .oMemWrEn(oMemWrEn), .oMemAddr(oMemAddr), .oMemWrData(oMemWrData),
      .oMemWrByt(oMemWrByt), .iMemRdData(iMemRdData)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Memory model: registered read, write on enable, bench pokes
   logic [63:0] mem [0:4095];
   logic        poke_en = 1'b0;
   logic [11:0] poke_idx;
   logic [63:0] poke_val;

   always @(posedge clk) begin
      if (oMemRdEn) iMemRdData <= mem[oMemAddr[14:3]];
      else          iMemRdData <= {$urandom(), $urandom()};
      if (oMemWrEn) mem[oMemAddr[14:3]] <= oMemWrData;
      if (poke_en)  mem[poke_idx] <= poke_val;
   end

   task automatic poke(input int idx, input logic [63:0] v);
      @(negedge clk);
      poke_idx = idx[11:0];
      poke_val = v;
      poke_en  = 1'b1;
      @(posedge clk);
      #1 poke_en = 1'b0;
   endtask

   // Expectations for the transaction in flight
   logic        active = 1'b0;
   int          t = 0;
   logic        e_rd, e_wr, e_fault;
   int          e_lat;
   logic [63:0] e_data, e_wdata, e_addr;

   // Per-cycle compare against the expectations
   always @(negedge clk) begin
      if (!active) begin
         chk("idle_ready", oReqReady, 64'd1);
         chk("idle_rden", oMemRdEn, 64'd0);
         chk("idle_wren", oMemWrEn, 64'd0);
         chk("idle_byt", oMemWrByt, 64'd0);
         chk("idle_valid", oRespValid, 64'd0);
      end else begin
         logic xr, xw, xv;
         t++;
         xr = e_rd && (t == 1 || t == 2);
         xw = e_wr && (t == (e_rd ? 3 : 1));
         xv = (t >= e_lat);
         chk("busy_ready", oReqReady, 64'd0);
         chk("rden", oMemRdEn, {63'd0, xr});
         chk("wren", oMemWrEn, {63'd0, xw});
         chk("wrbyt", oMemWrByt, xw ? 64'd4 : 64'd0);
         if (xw) chk("wrdata", oMemWrData, e_wdata);
         if (xr || xw) chk("memaddr", oMemAddr, e_addr);
         chk("resp_valid", oRespValid, {63'd0, xv});
         if (xv) begin
            chk("resp_data", oRespData, e_data);
            chk("resp_fault", oRespFault, {63'd0, e_fault});
         end
      end
   end

   // Behavioural model of one request, from byte-level rules
   task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [63:0] addr, input logic [63:0] wd);
      int nb, off;
      logic [63:0] dw, v;
      nb  = 1 << sz;
      off = int'(addr[2:0]);
      e_addr  = addr & ~64'h7;
      e_fault = ((off % nb) != 0) || (addr < BASE) || (addr >= LIMIT);
      e_data  = 64'd0;
      e_wdata = 64'd0;
      if (e_fault) begin
         e_rd = 1'b0; e_wr = 1'b0; e_lat = 1;
      end else begin
         dw = mem[addr[14:3]];
         if (!wr) begin
            v = 64'd0;
            for (int i = 0; i < 8; i++)
               if (i < nb) v[8*i +: 8] = dw[8*(off+i) +: 8];
            if (sg && nb < 8 && v[8*nb-1])
               for (int i = 0; i < 8; i++)
                  if (i >= nb) v[8*i +: 8] = 8'hFF;
            e_data = v; e_rd = 1'b1; e_wr = 1'b0; e_lat = 3;
         end else begin
            v = dw;
            for (int i = 0; i < 8; i++)
               if (i < nb) v[8*(off+i) +: 8] = wd[8*i +: 8];
            e_wdata = v; e_wr = 1'b1; e_rd = (nb < 8); e_lat = (nb < 8) ? 4 : 2;
         end
      end
   endtask

   task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [63:0] addr, input logic [63:0] wd);
      @(negedge clk); #1;
      model(wr, sz, sg, addr, wd);
      iReqWr = wr; iReqSize = sz; iReqSigned = sg; iReqAddr = addr; iReqWrData = wd;
      iReqValid = 1'b1;
      @(posedge clk); #1;
      iReqValid = 1'b0;
      t = 0;
      active = 1'b1;
   endtask

   task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [63:0] addr, input logic [63:0] wd, input int hold,
                         output logic [63:0] rdata, output logic rfault);
      int n;
      drive(wr, sz, sg, addr, wd);
      n = 0;
      while (!oRespValid && n < 20) begin
         @(negedge clk); #1; n++;
      end
      tests++;
      if (!oRespValid) begin
         fails++;
         $display("FAIL resp_timeout: no response within 20 cycles at %0t", $time);
      end
      repeat (hold) begin @(negedge clk); #1; end
      rdata  = oRespData;
      rfault = oRespFault;
      iRespReady = 1'b1;
      @(posedge clk); #1;
      iRespReady = 1'b0;
      active = 1'b0;
   endtask

   localparam logic [63:0] INIT = 64'h1122_3344_5566_7788;

   initial begin
      logic [63:0] d;
      logic f;
      #200_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d;
      logic        f;
      logic [63:0] a;
      int          sel;
      iReset = 1'b0; iReqValid = 1'b0; iReqWr = 1'b0; iReqSize = 2'd0; iReqSigned = 1'b0;
      iReqAddr = 64'd0; iReqWrData = 64'd0; iRespReady = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #2 iReset = 1'b1;
      #1;
      chk("rst_ready", oReqReady, 64'd1);
      chk("rst_valid", oRespValid, 64'd0);
      chk("rst_data", oRespData, 64'd0);
      chk("rst_fault", oRespFault, 64'd0);
      chk("rst_rden", oMemRdEn, 64'd0);
      chk("rst_wren", oMemWrEn, 64'd0);
      chk("rst_addr", oMemAddr, 64'd0);
      chk("rst_wdata", oMemWrData, 64'd0);
      chk("rst_byt", oMemWrByt, 64'd0);

      // Byte, half, word and doubleword loads
      poke(1, INIT);
      do_req(1'b0, 2'd0, 1'b1, 64'h8000_0008, 64'd0, 0, d, f);
      chk("lb_signed", d, 64'hFFFF_FFFF_FFFF_FF88);
      do_req(1'b0, 2'd0, 1'b0, 64'h8000_000F, 64'd0, 0, d, f);
      chk("lbu", d, 64'h11);
      do_req(1'b0, 2'd1, 1'b0, 64'h8000_000A, 64'd0, 0, d, f);
      chk("lhu", d, 64'h5566);
      do_req(1'b0, 2'd2, 1'b1, 64'h8000_0008, 64'd0, 0, d, f);
      chk("lw_signed", d, 64'h0000_0000_5566_7788);
      do_req(1'b0, 2'd3, 1'b1, 64'h8000_0008, 64'd0, 0, d, f);
      chk("ld", d, INIT);

      // Partial store and full store
      do_req(1'b1, 2'd0, 1'b0, 64'h8000_0009, 64'hAB, 0, d, f);
      chk("sb_resp", d, 64'd0);
      #1 chk("sb_mem", mem[1], 64'h1122_3344_5566_AB88);
      do_req(1'b1, 2'd3, 1'b0, 64'h8000_0010, 64'hDEAD_BEEF, 0, d, f);
      #1 chk("sd_mem", mem[2], 64'h0000_0000_DEAD_BEEF);

      // Faults and range boundary
      poke(1, INIT);
      do_req(1'b0, 2'd1, 1'b0, 64'h8000_0009, 64'd0, 0, d, f);
      chk("lh_misaligned", {63'd0, f}, 64'd1);
      do_req(1'b0, 2'd2, 1'b0, 64'h7FFF_FFF0, 64'd0, 0, d, f);
      chk("lw_below_base", {63'd0, f}, 64'd1);
      poke(4095, 64'hCAFE_F00D_1234_5678);
      do_req(1'b0, 2'd3, 1'b0, 64'h8000_7FF8, 64'd0, 0, d, f);
      chk("ld_last", d, 64'hCAFE_F00D_1234_5678);
      do_req(1'b0, 2'd0, 1'b0, 64'h8000_8000, 64'd0, 0, d, f);
      chk("lb_past_end", {63'd0, f}, 64'd1);

      // Backpressure
      do_req(1'b0, 2'd1, 1'b1, 64'h8000_000C, 64'd0, 5, d, f);
      chk("bp_lh", d, 64'h0000_0000_0000_3344);

      // Randomized traffic
      for (int k = 0; k < 300; k++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = BASE - 64'd8 - 64'($urandom_range(0, 64));
         else if (sel == 1) a = LIMIT + 64'($urandom_range(0, 64));
         else               a = BASE + 64'($urandom_range(0, 511));
         do_req(1'($urandom()), 2'($urandom()), 1'($urandom()), a,
                {$urandom(), $urandom()}, $urandom_range(0, 3), d, f);
      end

      // Reset in the capture cycle of a partial store
      poke(1, INIT);
      drive(1'b1, 2'd0, 1'b0, 64'h8000_0009, 64'hAB);
      @(negedge clk); @(negedge clk);
      #2;
      active = 1'b0;
      iReset = 1'b0;
      #1;
      chk("rstmid_rden", oMemRdEn, 64'd0);
      chk("rstmid_wren", oMemWrEn, 64'd0);
      chk("rstmid_ready", oReqReady, 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk); #2 iReset = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("rstmid_mem", mem[1], INIT);
      chk("rstmid_ready_after", oReqReady, 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
